kpn_bcd_stage: RTL and testbench

- KPN process node that sits directly upstream of the LCD display node.
- Pops 16-bit unsigned binary tokens from its input FIFO channel and converts each to four packed BCD digits using sequential double-dabble, one bit per cycle.
- Holds each result stable on the display node's 16-bit entry port until that node pulses its rd line.
- Values above 9999 saturate to 9999 and set a sticky overflow flag.

---
 rtl/kpn_bcd_stage.sv | 111 +++++++++++
 tb/tb_kpn_bcd_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/kpn_bcd_stage.sv
// KPN stage: pops binary tokens from a FIFO, converts them to packed BCD by
// sequential double-dabble and holds each result until the display node reads it.
module kpn_bcd_stage #(
  parameter int unsigned DATA_W    = 16,
  parameter logic [15:0] SAT_VALUE = 16'h9999
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_empty,
  output logic              in_rd,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_rd,
  output logic              overflow
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned BCD_W = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [BCD_W-1:0]  r_bcd;
  logic [BCD_W-1:0]  w_bcd_adj;
  logic [CNT_W-1:0]  r_cnt;
  logic [15:0]       r_out_data;
  logic              r_out_valid;
  logic              r_overflow;
  logic              w_last;

  assign w_last    = (r_cnt == CNT_W'(DATA_W - 1));
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // in_rd is qualified with reset_n so no pop can be issued while held in reset
  always_comb begin
    w_state_nxt = r_state;
    in_rd       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!in_empty && !r_out_valid) begin
          in_rd       = reset_n;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < BCD_W / 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift     <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (r_out_valid && out_rd) r_out_valid <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_shift <= in_data;
          r_bcd   <= '0;
          r_cnt   <= '0;
        end
        S_SHIFT: begin
          r_bcd   <= {w_bcd_adj[BCD_W-2:0], r_shift[DATA_W-1]};
          r_shift <= {r_shift[DATA_W-2:0], 1'b0};
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_DONE: begin
          if (r_bcd[BCD_W-1:16] != '0) begin
            r_out_data <= SAT_VALUE;
            r_overflow <= 1'b1;
          end else begin
            r_out_data <= r_bcd[15:0];
          end
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kpn_bcd_stage.sv
// Self-checking bench for kpn_bcd_stage: FIFO model upstream, directed tables,
// multi-cycle handshake sequences and randomized tokens against an arithmetic model.
module tb_kpn_bcd_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_data;
  logic        in_empty;
  logic        in_rd;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_rd = 1'b0;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  logic [15:0] fifo_mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_cnt = 0;
  logic [15:0] fifo_dout = '0;

  assign in_empty = (wr_ptr == rd_ptr);
  assign in_data  = fifo_dout;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (in_rd) begin
      fifo_dout <= fifo_mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
      pop_cnt   <= pop_cnt + 1;
    end
  end

  kpn_bcd_stage #(.DATA_W(16), .SAT_VALUE(16'h9999)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_empty (in_empty),
    .in_rd    (in_rd),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_rd   (out_rd),
    .overflow (overflow)
  );

  typedef struct {
    int          tok;
    logic [15:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  function automatic logic [15:0] bcd_ref(input int v);
    if (v > 9999) return 16'h9999;
    return 16'((((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
               (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int v);
    fifo_mem[wr_ptr % 64] = 16'(v);
    wr_ptr++;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic consume(input string tag);
    out_rd = 1'b1;
    @(negedge clock);
    out_rd = 1'b0;
    chk({tag, "_consumed"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_token(input int v, input logic [15:0] exp_d, input logic exp_o, input string tag);
    int n;
    push(v);
    wait_valid(40, n);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_o));
    consume(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   n, p, lat, v, dly;
    logic ovf_m;

    vecs[0] = '{0,     16'h0000, 1'b0};
    vecs[1] = '{9,     16'h0009, 1'b0};
    vecs[2] = '{10,    16'h0010, 1'b0};
    vecs[3] = '{9999,  16'h9999, 1'b0};
    vecs[4] = '{10000, 16'h9999, 1'b1};
    vecs[5] = '{65535, 16'h9999, 1'b1};
    vecs[6] = '{5,     16'h0005, 1'b1};

    // power-on reset
    repeat (3) @(negedge clock);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_rd", 32'(in_rd), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // single token latency and no pop while holding
    p = pop_cnt;
    push(1234);
    #1;
    chk("lat_in_rd_now", 32'(in_rd), 32'd1);
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clock);
      if (out_valid) lat = k;
    end
    chk("lat_cycles", 32'(lat), 32'd20);
    chk("lat_pops", 32'(pop_cnt - p), 32'd1);
    chk("lat_data", 32'(out_data), 32'h1234);
    push(5);
    repeat (10) @(negedge clock);
    chk("hold_no_pop", 32'(pop_cnt - p), 32'd1);
    chk("hold_valid", 32'(out_valid), 32'd1);
    out_rd = 1'b1;
    #1;
    chk("simul_in_rd_blocked", 32'(in_rd), 32'd0);
    @(negedge clock);
    out_rd = 1'b0;
    #1;
    chk("simul_valid_cleared", 32'(out_valid), 32'd0);
    chk("simul_in_rd_next", 32'(in_rd), 32'd1);
    wait_valid(40, n);
    chk("second_data", 32'(out_data), 32'h0005);
    chk("second_data_lat", 32'(n), 32'd20);
    consume("second");

    // boundary and saturation table
    for (int i = 0; i < 7; i++)
      run_token(vecs[i].tok, vecs[i].exp_data, vecs[i].exp_ovf, $sformatf("vec%0d", i));

    // backpressure with two queued tokens
    p = pop_cnt;
    push(42);
    push(7);
    wait_valid(40, n);
    chk("bp_first_data", 32'(out_data), 32'h0042);
    chk("bp_first_pops", 32'(pop_cnt - p), 32'd1);
    repeat (50) @(negedge clock);
    chk("bp_still_one_pop", 32'(pop_cnt - p), 32'd1);
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    consume("bp_first");
    wait_valid(40, n);
    chk("bp_second_data", 32'(out_data), 32'h0007);
    chk("bp_second_pops", 32'(pop_cnt - p), 32'd2);
    consume("bp_second");

    // long out_rd overlapping the next conversion
    p = pop_cnt;
    push(321);
    push(4567);
    wait_valid(40, n);
    chk("long_first_data", 32'(out_data), 32'h0321);
    out_rd = 1'b1;
    repeat (5) @(negedge clock);
    out_rd = 1'b0;
    chk("long_cleared", 32'(out_valid), 32'd0);
    chk("long_data_stable", 32'(out_data), 32'h0321);
    chk("long_second_popped", 32'(pop_cnt - p), 32'd2);
    wait_valid(40, n);
    chk("long_second_data", 32'(out_data), 32'h4567);
    repeat (3) @(negedge clock);
    chk("long_second_kept", 32'(out_valid), 32'd1);
    consume("long_second");

    // reset asserted mid-SHIFT aborts the token
    push(777);
    repeat (8) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    push(88);
    p = pop_cnt;
    repeat (3) @(negedge clock);
    chk("midrst_in_rd", 32'(in_rd), 32'd0);
    chk("midrst_no_pop", 32'(pop_cnt - p), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("postrst_in_rd", 32'(in_rd), 32'd1);
    @(negedge clock);
    wait_valid(40, n);
    chk("postrst_data", 32'(out_data), 32'h0088);
    chk("postrst_lat", 32'(n + 1), 32'd20);
    consume("postrst");

    // randomized tokens against the arithmetic model
    ovf_m = 1'b0;
    for (int t = 0; t < 16; t++) begin
      v = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10000, 65535))
                                      : int'($urandom_range(0, 9999));
      if (v > 9999) ovf_m = 1'b1;
      push(v);
      wait_valid(40, n);
      chk($sformatf("rnd%0d_valid", t), 32'(out_valid), 32'd1);
      chk($sformatf("rnd%0d_data_v%0d", t, v), 32'(out_data), 32'(bcd_ref(v)));
      chk($sformatf("rnd%0d_ovf", t), 32'(overflow), 32'(ovf_m));
      dly = int'($urandom_range(0, 5));
      repeat (dly) @(negedge clock);
      chk($sformatf("rnd%0d_stable", t), 32'(out_data), 32'(bcd_ref(v)));
      consume($sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
